// File: rtl/branch_predictor.sv
// Direct-mapped branch target buffer with saturating-counter direction prediction and perf counters.
// Latency: lookup is combinational (0 cycles); updates become visible on the cycle after their edge.
// Backpressure: none; every update_valid pulse is consumed in the cycle it is presented.
module branch_predictor #(
    parameter int ADDR_W  = 32,
    parameter int ENTRIES = 16,
    parameter int CTR_W   = 2,
    parameter int STAT_W  = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [ADDR_W-1:0] lookup_pc,
    output logic              pred_hit,
    output logic              pred_taken,
    output logic [ADDR_W-1:0] pred_target,
    input  logic              update_valid,
    input  logic [ADDR_W-1:0] update_pc,
    input  logic              update_taken,
    input  logic [ADDR_W-1:0] update_target,
    input  logic              update_pred_taken,
    input  logic [ADDR_W-1:0] update_pred_target,
    output logic              mispredict,
    output logic [STAT_W-1:0] branch_count,
    output logic [STAT_W-1:0] mispredict_count
);

    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = ADDR_W - IDX_W - 2;

    // Counter constants: weakly taken is the MSB alone, weakly not-taken sits just below it.
    localparam int unsigned WT_I = 1 << (CTR_W - 1);
    localparam logic [CTR_W-1:0] CTR_MAX = '1;
    localparam logic [CTR_W-1:0] CTR_WT  = CTR_W'(WT_I);
    localparam logic [CTR_W-1:0] CTR_WNT = CTR_W'(WT_I - 1);

    typedef struct packed {
        logic              valid;
        logic [TAG_W-1:0]  tag;
        logic [ADDR_W-1:0] target;
        logic [CTR_W-1:0]  ctr;
    } entry_t;

    // Flop-based storage so a single reset cycle clears every entry.
    entry_t btb_q [ENTRIES];

    logic [IDX_W-1:0] lk_idx;
    logic [TAG_W-1:0] lk_tag;
    entry_t           lk_ent;

    logic [IDX_W-1:0] up_idx;
    logic [TAG_W-1:0] up_tag;
    entry_t           up_ent;
    entry_t           up_next;
    logic             up_hit;
    logic             up_write;

    // Word-alignment bits of the update PC carry no information for the table.
    logic unused_update_pc_bits;
    assign unused_update_pc_bits = ^update_pc[1:0];

    assign lk_idx = lookup_pc[IDX_W+1:2];
    assign lk_tag = lookup_pc[ADDR_W-1:IDX_W+2];
    assign up_idx = update_pc[IDX_W+1:2];
    assign up_tag = update_pc[ADDR_W-1:IDX_W+2];

    // Same-cycle lookup reads the registered table only, so a concurrent update is never bypassed.
    always_comb begin
        lk_ent      = btb_q[lk_idx];
        pred_hit    = lk_ent.valid && (lk_ent.tag == lk_tag);
        pred_taken  = pred_hit && lk_ent.ctr[CTR_W-1];
        pred_target = pred_taken ? lk_ent.target : (lookup_pc + ADDR_W'(4));
    end

    // A resolved transfer disagrees with its carried prediction on direction, or on target when taken.
    assign mispredict = update_valid &&
                        ((update_pred_taken != update_taken) ||
                         (update_taken && (update_pred_target != update_target)));

    // Next value of the addressed entry: train on hit, allocate only taken misses.
    always_comb begin
        up_ent   = btb_q[up_idx];
        up_hit   = up_ent.valid && (up_ent.tag == up_tag);
        up_next  = up_ent;
        up_write = 1'b0;
        if (update_valid) begin
            if (up_hit) begin
                up_write = 1'b1;
                if (update_taken) begin
                    if (up_ent.ctr != CTR_MAX) begin
                        up_next.ctr = up_ent.ctr + CTR_W'(1);
                    end
                    up_next.target = update_target;
                end else if (up_ent.ctr != '0) begin
                    up_next.ctr = up_ent.ctr - CTR_W'(1);
                end
            end else if (update_taken) begin
                up_write       = 1'b1;
                up_next.valid  = 1'b1;
                up_next.tag    = up_tag;
                up_next.target = update_target;
                up_next.ctr    = CTR_WT;
            end
        end
    end

    // Table and perf counter state; reset wins over a same-cycle update.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                btb_q[i].valid  <= 1'b0;
                btb_q[i].tag    <= '0;
                btb_q[i].target <= '0;
                btb_q[i].ctr    <= CTR_WNT;
            end
            branch_count     <= '0;
            mispredict_count <= '0;
        end else begin
            if (up_write) begin
                btb_q[up_idx] <= up_next;
            end
            if (update_valid) begin
                branch_count <= branch_count + STAT_W'(1);
            end
            if (mispredict) begin
                mispredict_count <= mispredict_count + STAT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_branch_predictor.sv
// Directed and randomized bench for branch_predictor against a behavioural table model.
// Latency: lookup checked #1 after inputs change; counters checked #1 after each rising edge.
// Backpressure: none; the bench presents at most one update per cycle.
module tb_branch_predictor;

    localparam int ADDR_W  = 32;
    localparam int ENTRIES = 16;
    localparam int CTR_W   = 2;
    localparam int STAT_W  = 32;
    localparam int IDX_W   = $clog2(ENTRIES);
    localparam int CMAX    = (1 << CTR_W) - 1;
    localparam int WT      = 1 << (CTR_W - 1);
    localparam int WNT     = WT - 1;

    logic              clock;
    logic              reset;
    logic [ADDR_W-1:0] lookup_pc;
    logic              pred_hit;
    logic              pred_taken;
    logic [ADDR_W-1:0] pred_target;
    logic              update_valid;
    logic [ADDR_W-1:0] update_pc;
    logic              update_taken;
    logic [ADDR_W-1:0] update_target;
    logic              update_pred_taken;
    logic [ADDR_W-1:0] update_pred_target;
    logic              mispredict;
    logic [STAT_W-1:0] branch_count;
    logic [STAT_W-1:0] mispredict_count;

    branch_predictor #(
        .ADDR_W (ADDR_W),
        .ENTRIES(ENTRIES),
        .CTR_W  (CTR_W),
        .STAT_W (STAT_W)
    ) dut (
        .clock             (clock),
        .reset             (reset),
        .lookup_pc         (lookup_pc),
        .pred_hit          (pred_hit),
        .pred_taken        (pred_taken),
        .pred_target       (pred_target),
        .update_valid      (update_valid),
        .update_pc         (update_pc),
        .update_taken      (update_taken),
        .update_target     (update_target),
        .update_pred_taken (update_pred_taken),
        .update_pred_target(update_pred_target),
        .mispredict        (mispredict),
        .branch_count      (branch_count),
        .mispredict_count  (mispredict_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference model: per-slot state held as plain integers, keyed by slot number.
    bit          m_valid [ENTRIES];
    int unsigned m_tag   [ENTRIES];
    int unsigned m_tgt   [ENTRIES];
    int          m_ctr   [ENTRIES];
    int unsigned m_bc;
    int unsigned m_mc;
    bit          model_known;

    int n_checks;
    int n_errors;

    function automatic int slot_of(input logic [ADDR_W-1:0] pc);
        return int'((pc >> 2) % ENTRIES);
    endfunction

    function automatic int unsigned tag_of(input logic [ADDR_W-1:0] pc);
        return int'(pc >> (IDX_W + 2));
    endfunction

    function automatic void model_lookup(input logic [ADDR_W-1:0] pc, output logic hit,
                                         output logic taken, output logic [ADDR_W-1:0] tgt);
        int s;
        s     = slot_of(pc);
        hit   = m_valid[s] && (m_tag[s] == tag_of(pc));
        taken = hit && (m_ctr[s] >= WT);
        tgt   = taken ? m_tgt[s] : pc + 32'd4;
    endfunction

    function automatic logic model_misp();
        if (!update_valid) return 1'b0;
        if (update_pred_taken != update_taken) return 1'b1;
        return update_taken && (update_pred_target != update_target);
    endfunction

    task automatic check(input string tag, input logic [ADDR_W-1:0] obs, input logic [ADDR_W-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive one cycle's inputs, then compare combinational outputs against the model.
    task automatic set_in(input logic rst, input logic uv, input logic [ADDR_W-1:0] upc,
                          input logic ut, input logic [ADDR_W-1:0] utg, input logic upt,
                          input logic [ADDR_W-1:0] uptg, input logic [ADDR_W-1:0] lpc);
        logic h, t;
        logic [ADDR_W-1:0] tg;
        reset              = rst;
        update_valid       = uv;
        update_pc          = upc;
        update_taken       = ut;
        update_target      = utg;
        update_pred_taken  = upt;
        update_pred_target = uptg;
        lookup_pc          = lpc;
        #1;
        check("mispredict", {31'd0, mispredict}, {31'd0, model_misp()});
        if (model_known) begin
            model_lookup(lpc, h, t, tg);
            check("pred_hit", {31'd0, pred_hit}, {31'd0, h});
            check("pred_taken", {31'd0, pred_taken}, {31'd0, t});
            check("pred_target", pred_target, tg);
        end
    endtask

    // Advance one clock, apply the same rules to the model, and compare the counters.
    task automatic tick();
        logic h, t, mp;
        logic [ADDR_W-1:0] tg;
        int s;
        mp = model_misp();
        model_lookup(update_pc, h, t, tg);
        s = slot_of(update_pc);
        @(posedge clock);
        if (reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                m_valid[i] = 1'b0;
                m_tag[i]   = 0;
                m_tgt[i]   = 0;
                m_ctr[i]   = WNT;
            end
            m_bc        = 0;
            m_mc        = 0;
            model_known = 1'b1;
        end else if (update_valid) begin
            if (h) begin
                if (update_taken) begin
                    m_ctr[s] = (m_ctr[s] + 1 > CMAX) ? CMAX : m_ctr[s] + 1;
                    m_tgt[s] = update_target;
                end else begin
                    m_ctr[s] = (m_ctr[s] - 1 < 0) ? 0 : m_ctr[s] - 1;
                end
            end else if (update_taken) begin
                m_valid[s] = 1'b1;
                m_tag[s]   = tag_of(update_pc);
                m_tgt[s]   = update_target;
                m_ctr[s]   = WT;
            end
            m_bc = m_bc + 1;
            if (mp) m_mc = m_mc + 1;
        end
        #1;
        if (model_known) begin
            check("branch_count", branch_count, m_bc);
            check("mispredict_count", mispredict_count, m_mc);
        end
        @(negedge clock);
    endtask

    task automatic idle(input logic [ADDR_W-1:0] lpc);
        set_in(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, lpc);
    endtask

    initial begin
        n_checks    = 0;
        n_errors    = 0;
        model_known = 1'b0;
        m_bc        = 0;
        m_mc        = 0;
        @(negedge clock);

        // Reset, then an empty table misses and predicts fall-through.
        set_in(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h40);
        tick();
        idle(32'h40);
        check("reset_hit", {31'd0, pred_hit}, 32'd0);
        check("reset_target", pred_target, 32'h44);
        check("reset_bc", branch_count, 32'd0);
        tick();

        // First taken update allocates and mispredicts.
        set_in(1'b0, 1'b1, 32'h40, 1'b1, 32'h80, 1'b0, 32'h44, 32'h40);
        check("alloc_misp", {31'd0, mispredict}, 32'd1);
        tick();
        idle(32'h40);
        check("alloc_hit", {31'd0, pred_hit}, 32'd1);
        check("alloc_taken", {31'd0, pred_taken}, 32'd1);
        check("alloc_target", pred_target, 32'h80);
        check("alloc_bc", branch_count, 32'd1);
        check("alloc_mc", mispredict_count, 32'd1);
        tick();

        // Saturate up, then walk the counter down past zero.
        repeat (2) begin
            set_in(1'b0, 1'b1, 32'h40, 1'b1, 32'h80, 1'b1, 32'h80, 32'h40);
            tick();
        end
        set_in(1'b0, 1'b1, 32'h40, 1'b0, 32'h0, 1'b1, 32'h80, 32'h40);
        tick();
        idle(32'h40);
        check("sat_one_nt_taken", {31'd0, pred_taken}, 32'd1);
        set_in(1'b0, 1'b1, 32'h40, 1'b0, 32'h0, 1'b1, 32'h80, 32'h40);
        tick();
        idle(32'h40);
        check("sat_two_nt_taken", {31'd0, pred_taken}, 32'd0);
        check("sat_two_nt_target", pred_target, 32'h44);
        repeat (2) begin
            set_in(1'b0, 1'b1, 32'h40, 1'b0, 32'h0, 1'b0, 32'h44, 32'h40);
            tick();
        end
        set_in(1'b0, 1'b1, 32'h40, 1'b1, 32'h80, 1'b0, 32'h44, 32'h40);
        tick();
        idle(32'h40);
        check("floor_then_taken", {31'd0, pred_taken}, 32'd0);
        check("floor_still_hit", {31'd0, pred_hit}, 32'd1);
        tick();

        // Aliasing into slot 0, and a not-taken miss never allocates.
        set_in(1'b0, 1'b1, 32'h80, 1'b1, 32'h100, 1'b0, 32'h84, 32'h80);
        tick();
        idle(32'h40);
        check("alias_old_miss", {31'd0, pred_hit}, 32'd0);
        idle(32'h80);
        check("alias_new_target", pred_target, 32'h100);
        set_in(1'b0, 1'b1, 32'hC4, 1'b0, 32'h0, 1'b0, 32'hC8, 32'hC4);
        tick();
        idle(32'hC4);
        check("nt_no_alloc", {31'd0, pred_hit}, 32'd0);
        tick();

        // Same-cycle lookup sees the pre-update table.
        set_in(1'b0, 1'b1, 32'h200, 1'b1, 32'h300, 1'b0, 32'h204, 32'h200);
        check("nobypass_hit", {31'd0, pred_hit}, 32'd0);
        tick();
        idle(32'h200);
        check("after_upd_target", pred_target, 32'h300);
        set_in(1'b0, 1'b1, 32'h200, 1'b1, 32'h300, 1'b1, 32'h300, 32'h200);
        check("correct_pred", {31'd0, mispredict}, 32'd0);
        tick();
        set_in(1'b0, 1'b1, 32'h200, 1'b1, 32'h300, 1'b1, 32'h304, 32'h200);
        check("wrong_target", {31'd0, mispredict}, 32'd1);
        tick();

        // Reset with a concurrent update discards the update.
        set_in(1'b1, 1'b1, 32'h40, 1'b1, 32'h80, 1'b0, 32'h44, 32'h200);
        tick();
        idle(32'h40);
        check("rst_upd_miss", {31'd0, pred_hit}, 32'd0);
        check("rst_upd_bc", branch_count, 32'd0);
        check("rst_upd_mc", mispredict_count, 32'd0);
        tick();

        // Randomized traffic over a small PC pool so hits, aliasing and saturation all occur.
        for (int n = 0; n < 600; n++) begin
            logic [ADDR_W-1:0] upc, lpc, utg, uptg;
            logic ut, upt, h, t, uv, rst;
            upc = ($urandom_range(0, 63) << 2) | $urandom_range(0, 3);
            lpc = ($urandom_range(0, 3) == 0) ? upc
                                              : (($urandom_range(0, 63) << 2) | $urandom_range(0, 3));
            utg = $urandom_range(0, 15) << 4;
            ut  = $urandom_range(0, 2) != 0;
            uv  = $urandom_range(0, 3) != 0;
            rst = $urandom_range(0, 99) == 0;
            if ($urandom_range(0, 3) != 0) begin
                model_lookup(upc, h, t, uptg);
                upt = t;
            end else begin
                upt  = $urandom_range(0, 1) != 0;
                uptg = $urandom_range(0, 15) << 4;
            end
            set_in(rst, uv, upc, ut, utg, upt, uptg, lpc);
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

endmodule
